vram: RTL and testbench
=======================

// Module: vram
//
// PURPOSE
// - Single-port 1 KiB x 8-bit video RAM for the PPU: tile/map byte store read and written by PPU logic.
// - Synchronous write and registered synchronous read on one clock; one shared address bus.
// - Sits between the PPU fetch/CPU-access arbitration (drives we/addrs/byte) and the pixel pipeline (consumes out).
//
// PARAMETERS
// - ADDR_W  10            address width in bits
// - DATA_W  8             data width in bits
// - DEPTH   1<<ADDR_W     number of words (1024)
//
// PORTS
// - clk    in   1        rising-edge clock for all state
// - rst_n  in   1        asynchronous reset, active low
// - we     in   1        write enable; 1 = write byte to mem[addrs] this edge
// - addrs  in   ADDR_W   word address, used for both write and read
// - byte   in   DATA_W   write data
// - out    out  DATA_W   registered read data
// - One clock; reset is asynchronous and active-low.
// - Port order is clk, rst_n, we, addrs, byte, out.
// - The port name "byte" requires Verilog-2001 source; do not compile as SystemVerilog.
//
// BEHAVIOUR
// - Reset (rst_n=0, asynchronous):
//   - out clears to 0 immediately and holds 0 while rst_n=0.
//   - Memory array is NOT cleared; writes are ignored while in reset.
// - Release: first active edge is the first rising clk edge with rst_n=1. No synchronizer is inside this block.
// - Write, every rising clk edge with rst_n=1 and we=1:
//   - mem[addrs] <= byte.
// - Read, every rising clk edge with rst_n=1:
//   - out <= mem[addrs]; latency 1 cycle from address to out.
//   - out holds its value between edges.
// - Read-during-write (same edge, we=1): write-first.
//   - out takes the new byte, not the old contents.
// - Address range: all 1024 addresses are valid; no wrap logic needed (full decode of ADDR_W bits).
// - X/Z on addrs or we: behaviour is undefined. The bench must drive known values.
// - Power-up array contents are undefined. Consumers must write before reading.
// - Simulation models may zero-initialise the array.
// - No handshake or busy signal: every cycle accepts one access.
// - Implementation: reg array [0:DEPTH-1] inferrable as block RAM.
//   - The out register is the only reset flop; the array has no reset.
//
// STRUCTURE
// - Shared package/header: VRAM_ADDR_W=10, VRAM_DATA_W=8, VRAM_DEPTH=1024.
//   - Other PPU blocks reuse these for address generation.
// - Single flat module; no sub-module required.
//   - Optional: split the array into vram_bank (pure storage, no reset) plus the output register in the wrapper.
//
// TESTING
// - Clock period 40 time units; check out one full period after each access.
// - Write/readback: we=1 addrs=0x004 byte=0x02, one edge.
//   - Then we=0 addrs=0x004, one edge -> out=2.
// - Second location: we=1 addrs=0x005 byte=0x03, one edge.
//   - Then read 0x005 -> out=3; then read 0x004 -> out=2 (no aliasing).
// - Read-during-write: we=1 addrs=0x010 byte=0xA5, one edge -> out=0xA5 on that same edge.
// - Boundaries: write 0x3FF=0x7E and 0x000=0x81.
//   - Read each -> 0x7E and 0x81; neighbours unchanged.
// - Reset mid-operation: with out=0x7E, drop rst_n between edges.
//   - out=0 immediately, without a clock edge.
//   - A write attempted during reset is not stored.
//   - After release, reading 0x3FF -> 0x7E (array preserved).
// - Latency: change addrs each cycle across 0x004/0x005.
//   - out follows one cycle behind: 2, 3, 2.

Source files
------------

// File: rtl/vram_pkg.sv
// vram_pkg: shared VRAM geometry constants.
// Other PPU blocks import these for address generation and data-path sizing.
package vram_pkg;
    localparam int VRAM_ADDR_W = 10;
    localparam int VRAM_DATA_W = 8;
    localparam int VRAM_DEPTH  = 1 << VRAM_ADDR_W;
endpackage

// File: rtl/vram_bank.sv
// vram_bank: pure storage array for the video RAM, no reset.
// Ports:
//   clk    - rising-edge clock for writes
//   we     - write enable (already qualified by reset in the wrapper)
//   addrs  - word address, shared by write and read
//   wbyte  - write data
//   rdata  - asynchronous read of mem[addrs]; the wrapper registers it
// Contents are undefined at power-up; consumers write before reading.
module vram_bank
    import vram_pkg::*;
#(
    parameter int ADDR_W = VRAM_ADDR_W,
    parameter int DATA_W = VRAM_DATA_W,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addrs,
    input  logic [DATA_W-1:0] wbyte,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we)
            mem[addrs] <= wbyte;
    end

    assign rdata = mem[addrs];

endmodule

// File: rtl/vram.sv
// vram: single-port 1 KiB x 8 video RAM with a registered read port.
// Ports:
//   clk    - rising-edge clock for all state
//   rst_n  - asynchronous active-low reset; clears out only
//   we     - write enable; 1 = store wbyte at addrs this edge
//   addrs  - word address used for both write and read
//   wbyte  - write data byte
//   out    - registered read data, one cycle after the address
// Read-during-write on the same address is write-first: out takes wbyte.
module vram
    import vram_pkg::*;
#(
    parameter int ADDR_W = VRAM_ADDR_W,
    parameter int DATA_W = VRAM_DATA_W,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] addrs,
    input  logic [DATA_W-1:0] wbyte,
    output logic [DATA_W-1:0] out
);

    logic [DATA_W-1:0] rdata;

    // Writes are blocked while reset is held so the array survives a reset
    // pulse untouched.
    vram_bank #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) u_bank (
        .clk  (clk),
        .we   (we & rst_n),
        .addrs(addrs),
        .wbyte(wbyte),
        .rdata(rdata)
    );

    // Write-first: the bypass returns the incoming byte instead of the
    // pre-write array contents on a same-edge write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            out <= '0;
        else
            out <= we ? wbyte : rdata;
    end

endmodule

// File: tb/tb_vram.sv
module tb_vram;
    import vram_pkg::*;

    typedef struct {
        bit         known;
        logic [7:0] val;
        string      name;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   we = 1'b0;
    logic [VRAM_ADDR_W-1:0] addrs = '0;
    logic [VRAM_DATA_W-1:0] wbyte = '0;
    logic [VRAM_DATA_W-1:0] out;

    int checks = 0;
    int errors = 0;

    exp_t       sb[$];
    logic [7:0] model[int];   // addresses written so far -> last byte

    vram dut (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (we),
        .addrs(addrs),
        .wbyte(wbyte),
        .out  (out)
    );

    always #20 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, req);
        end
    endtask

    // One access: drive at the falling edge, record what a RAM with
    // write-first semantics must present after the next rising edge.
    task automatic access(input bit w, input int a, input logic [7:0] d, input string name);
        exp_t e;
        @(negedge clk);
        we    = w;
        addrs = a[VRAM_ADDR_W-1:0];
        wbyte = d;
        e.name = name;
        if (w) begin
            e.known = 1;
            e.val   = d;
            model[a] = d;
        end else if (model.exists(a)) begin
            e.known = 1;
            e.val   = model[a];
        end else begin
            e.known = 0;
            e.val   = '0;
        end
        sb.push_back(e);
    endtask

    // Monitor: each rising edge consumes one pending access.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                if (e.known)
                    check(e.name, out, e.val);
            end
        end
    end

    initial begin
        int a;
        #30;
        check("reset_out", out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // write / readback, second location, no aliasing
        access(1, 'h004, 8'h02, "wr_004");
        access(0, 'h004, 8'h00, "rd_004");
        access(1, 'h005, 8'h03, "wr_005");
        access(0, 'h005, 8'h00, "rd_005");
        access(0, 'h004, 8'h00, "rd_004_again");

        // read-during-write returns the new byte
        access(1, 'h010, 8'hA5, "rdw_010");
        access(0, 'h010, 8'h00, "rd_010");

        // boundaries and their neighbours
        access(1, 'h3FE, 8'h11, "wr_3fe");
        access(1, 'h001, 8'h22, "wr_001");
        access(1, 'h3FF, 8'h7E, "wr_3ff");
        access(1, 'h000, 8'h81, "wr_000");
        access(0, 'h3FF, 8'h00, "rd_3ff");
        access(0, 'h000, 8'h00, "rd_000");
        access(0, 'h3FE, 8'h00, "rd_3fe_nbr");
        access(0, 'h001, 8'h00, "rd_001_nbr");

        // latency: address changes every cycle
        access(0, 'h004, 8'h00, "lat_0");
        access(0, 'h005, 8'h00, "lat_1");
        access(0, 'h004, 8'h00, "lat_2");

        // reset mid-operation with out = 0x7E
        access(0, 'h3FF, 8'h00, "rd_3ff_pre_rst");
        @(posedge clk);
        #10;
        check("out_pre_rst", out, 8'h7E);
        rst_n = 1'b0;
        #1;
        check("out_async_clr", out, 8'h00);
        @(negedge clk);
        we = 1'b1; addrs = 10'h3FF; wbyte = 8'h55;   // must not be stored
        @(posedge clk);
        #1;
        check("out_held_in_rst", out, 8'h00);
        @(negedge clk);
        we = 1'b0;
        rst_n = 1'b1;
        access(0, 'h3FF, 8'h00, "rd_3ff_post_rst");
        access(0, 'h000, 8'h00, "rd_000_post_rst");

        // randomized traffic over a small window at each end of the map
        for (int i = 0; i < 300; i++) begin
            a = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 15)
                                            : $urandom_range('h3F0, 'h3FF);
            access($urandom_range(0, 1) == 1, a, 8'($urandom), "rand");
        end

        // drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && sb.size() != 0; i++)
            @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
